// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for a 3-port register file: shares the sync write port between two
// requesters and tracks pending destinations for RAW stalls. RFWB_RR_EN selects round-robin ties.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 claim_valid,
    input  logic [AW-1:0]        claim_rd,
    input  logic                 wb0_valid,
    output logic                 wb0_ready,
    input  logic [AW-1:0]        wb0_rd,
    input  logic [DW-1:0]        wb0_data,
    input  logic                 wb1_valid,
    output logic                 wb1_ready,
    input  logic [AW-1:0]        wb1_rd,
    input  logic [DW-1:0]        wb1_data,
    input  logic [AW-1:0]        q_rs1,
    input  logic [AW-1:0]        q_rs2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_a3,
    output logic [DW-1:0]        rf_wd,
    output logic [(1<<AW)-1:0]   pend_vec
);
    localparam int NREG = 1 << AW;

    logic            gnt0, gnt1, accept;
    logic [AW-1:0]   sel_rd;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] pend, pend_nxt;

`ifdef RFWB_RR_EN
    logic last_gnt;  // 1 = wb1 took the most recent grant, so wb0 wins the next tie

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_gnt <= 1'b1;
        else if (accept) last_gnt <= gnt1;
    end

    always_comb begin
        gnt0 = wb0_valid && (!wb1_valid || last_gnt);
        gnt1 = wb1_valid && !gnt0;
    end
`else
    always_comb begin
        gnt0 = wb0_valid;
        gnt1 = wb1_valid && !wb0_valid;
    end
`endif

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;
    assign accept    = gnt0 || gnt1;
    assign sel_rd    = gnt0 ? wb0_rd   : wb1_rd;
    assign sel_data  = gnt0 ? wb0_data : wb1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= accept && (sel_rd != '0);
            if (accept) begin
                rf_a3 <= sel_rd;
                rf_wd <= sel_data;
            end
        end
    end

    // Clear on the commit edge; a same-edge claim of that register wins (new producer).
    always_comb begin
        pend_nxt = pend;
        if (rf_we) pend_nxt[rf_a3] = 1'b0;
        if (claim_valid && claim_rd != '0) pend_nxt[claim_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nxt;
    end

    assign pend_vec = pend;
    assign q_busy1  = pend[q_rs1];
    assign q_busy2  = pend[q_rs2];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a negedge monitor models grants, output stage and
// scoreboard; accepted writes are queued and popped when the DUT raises rf_we.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic claim_valid = 1'b0, wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic [AW-1:0] claim_rd = '0, wb0_rd = '0, wb1_rd = '0, q_rs1 = '0, q_rs2 = '0;
    logic [DW-1:0] wb0_data = '0, wb1_data = '0;
    logic wb0_ready, wb1_ready, q_busy1, q_busy2, rf_we;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;
    logic [NREG-1:0] pend_vec;

    int total = 0, bad = 0;
    wr_t expq[$];
    logic [NREG-1:0] m_pend;
    logic m_we, m_last;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .claim_valid(claim_valid), .claim_rd(claim_rd),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .pend_vec(pend_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven at posedge+1, so at the negedge they describe the coming edge.
    always @(negedge clk) begin
        logic g0, g1;
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
        logic [NREG-1:0] nxt;
        wr_t e;
        if (!rst_n) begin
            m_pend = '0; m_we = 1'b0; m_a3 = '0; m_wd = '0; m_last = 1'b1;
            expq.delete();
        end else begin
`ifdef RFWB_RR_EN
            g0 = wb0_valid && (!wb1_valid || m_last);
`else
            g0 = wb0_valid;
`endif
            g1 = wb1_valid && !g0;
            chk("wb0_ready", wb0_ready, g0);
            chk("wb1_ready", wb1_ready, g1);
            chk("rf_we", rf_we, m_we);
            chk("rf_a3", rf_a3, m_a3);
            chk("rf_wd", rf_wd, m_wd);
            chk("pend_vec", pend_vec, m_pend);
            chk("q_busy1", q_busy1, m_pend[q_rs1]);
            chk("q_busy2", q_busy2, m_pend[q_rs2]);
            if (rf_we) begin
                if (expq.size() == 0) chk("wr_unexpected", rf_we, 1'b0);
                else begin
                    e = expq.pop_front();
                    chk("sb_rd", rf_a3, e.rd);
                    chk("sb_data", rf_wd, e.data);
                end
            end
            nxt = m_pend;
            if (m_we) nxt[m_a3] = 1'b0;
            if (claim_valid && claim_rd != '0) nxt[claim_rd] = 1'b1;
            m_pend = nxt;
            if (g0 || g1) begin
                rd = g0 ? wb0_rd : wb1_rd;
                d  = g0 ? wb0_data : wb1_data;
                m_we = (rd != '0); m_a3 = rd; m_wd = d; m_last = g1;
                if (rd != '0) expq.push_back('{rd: rd, data: d});
            end else m_we = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        claim_valid = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] pat;
        #12;
        chk("rst_we", rf_we, 1'b0);
        chk("rst_a3", rf_a3, '0);
        chk("rst_wd", rf_wd, '0);
        chk("rst_pend", pend_vec, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1);

        // single wb0 write
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
        #2 chk("wb0_only_ready", wb0_ready, 1'b1);
        cyc(1); idle();
        #2 chk("wb0_only_we", rf_we, 1'b1);
        chk("wb0_only_wd", rf_wd, 32'hDEADBEEF);
        cyc(1);
        chk("wb0_only_we_drop", rf_we, 1'b0);
        cyc(1);

        // claim 7, write it back via wb1 two cycles later
        q_rs1 = 5'd7; q_rs2 = 5'd0;
        claim_valid = 1'b1; claim_rd = 5'd7;
        cyc(1); idle();
        chk("raw_busy_after_claim", q_busy1, 1'b1);
        cyc(1);
        wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h12;
        cyc(1); idle();
        chk("raw_busy_in_we", q_busy1, 1'b1);
        cyc(1);
        chk("raw_busy_cleared", q_busy1, 1'b0);
        cyc(1);

        // both requesters valid for four cycles
        wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h1111;
        wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); pat[i] = wb0_ready;
            cyc(1);
        end
`ifdef RFWB_RR_EN
        chk("tie_pattern", pat, 4'b0101);
`else
        chk("tie_pattern", pat, 4'b1111);
`endif
        wb0_valid = 1'b0;
        cyc(1); idle();
        cyc(2);

        // x0 write and x0 claim
        q_rs2 = 5'd0;
        wb0_valid = 1'b1; wb0_rd = 5'd0; wb0_data = 32'hFFFFFFFF;
        claim_valid = 1'b1; claim_rd = 5'd0;
        #2 chk("x0_ready", wb0_ready, 1'b1);
        cyc(1); idle();
        chk("x0_we", rf_we, 1'b0);
        chk("x0_pend", pend_vec, '0);
        cyc(1);

        // commit of rd3 on the same edge as a new claim of rd3
        q_rs2 = 5'd3;
        claim_valid = 1'b1; claim_rd = 5'd3;
        cyc(1); idle();
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h3333;
        cyc(1); idle();
        claim_valid = 1'b1; claim_rd = 5'd3;
        chk("same_edge_we", rf_we, 1'b1);
        cyc(1); idle();
        chk("same_edge_pend3", pend_vec[3], 1'b1);
        cyc(2);

        // async reset while a write is in flight and pend = {4,7}
        claim_valid = 1'b1; claim_rd = 5'd4;
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h33;
        cyc(1);
        claim_rd = 5'd7; wb0_rd = 5'd9; wb0_data = 32'h99;
        @(posedge clk); #2;
        chk("pre_rst_we", rf_we, 1'b1);
        chk("pre_rst_pend", pend_vec, 32'h0000_0090);
        #1 rst_n = 1'b0; idle();
        #1;
        chk("async_rst_we", rf_we, 1'b0);
        chk("async_rst_a3", rf_a3, '0);
        chk("async_rst_wd", rf_wd, '0);
        chk("async_rst_pend", pend_vec, '0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst_we", rf_we, 1'b0);
        cyc(2);
        chk("expq_left", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
